// File: rtl/dot_product_accum_if.sv
// rtl/dot_product_accum_if.sv - Job request, operand stream and result handshake bundle for dot_product_accum.
interface dot_product_accum_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [LEN_W-1:0]  length;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;
  logic              busy;
  logic              overflow;

  modport master (
    output start, length, in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, busy, overflow
  );

  modport slave (
    input  start, length, in_valid, a, b, out_ready,
    output in_ready, out_valid, result, busy, overflow
  );
endinterface

// File: rtl/dot_product_accum.sv
// rtl/dot_product_accum.sv - Streaming signed multiply-accumulate returning one dot product per job.
// Define DOT_PRODUCT_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module dot_product_accum #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8
) (
  input  logic                clock,
  input  logic                reset_L,
  dot_product_accum_if.slave  bus
);

  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                    state, state_next;
  logic signed [ACC_W-1:0]   acc, acc_next;
  logic        [LEN_W-1:0]   remaining, remaining_next;
  logic                      ovf, ovf_next;

  logic                      accept;
  logic signed [DATA_W-1:0]  op_a, op_b;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   acc_add;
  logic                      add_ovf;

`ifdef DOT_PRODUCT_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  // Operands are forced to zero unless a beat is taken, so junk on a/b never reaches state.
  always_comb begin
    accept   = (state == ACCUM) && bus.in_valid;
    op_a     = accept ? $signed(bus.a) : '0;
    op_b     = accept ? $signed(bus.b) : '0;
    prod     = PROD_W'(op_a) * PROD_W'(op_b);
    prod_ext = ACC_W'(prod);
    sum      = acc + prod_ext;
    add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
`ifdef DOT_PRODUCT_SATURATE_EN
    if (add_ovf) begin
      acc_add = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_add = sum;
    end
`else
    acc_add = sum;
`endif
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      remaining <= remaining_next;
      ovf       <= ovf_next;
    end
  end

  always_comb begin
    state_next     = state;
    acc_next       = acc;
    remaining_next = remaining;
    ovf_next       = ovf;
    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_next = '0;
          ovf_next = 1'b0;
          if (bus.length != '0) begin
            remaining_next = bus.length;
            state_next     = ACCUM;
          end else begin
            state_next = DONE;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_next       = acc_add;
          ovf_next       = ovf | add_ovf;
          remaining_next = remaining - 1'b1;
          if (remaining == LEN_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = acc;
  assign bus.overflow  = ovf;

endmodule

// File: doc/dot_product_accum.md
Name: dot_product_accum

Overview:
- Streaming signed multiply-accumulate stage. Consumes operand pairs (a, b) from an upstream matrix-fetch stage, whose addresses come from step counters, and returns one dot product per job.
- Sits directly downstream of the address/step counter and register library blocks in the matrix-multiply datapath.
- Its result is consumed by the writeback stage through a valid/ready handshake.

Parameters:
- DATA_W, 16, width of each signed operand a and b.
- ACC_W, 40, width of the signed accumulator and result; must be at least 2*DATA_W.
- LEN_W, 8, width of the job length field (maximum vector length 2^LEN_W - 1).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_L  input  1  asynchronous active-low reset.
- start  input  1  single-cycle job request; honoured only in IDLE.
- length  input  LEN_W  number of operand pairs in the job; sampled when start is accepted.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  block accepts an operand pair this cycle.
- a  input  DATA_W  signed operand A.
- b  input  DATA_W  signed operand B.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- result  output  ACC_W  signed dot product.
- busy  output  1  high whenever the state is not IDLE.
- overflow  output  1  sticky per-job signed accumulator overflow flag; valid alongside result.

Behaviour:
- Reset (asynchronous, reset_L=0): state=IDLE; accumulator=0; remaining count=0; in_ready=0; out_valid=0; result=0; busy=0; overflow=0. Asserting reset mid-job aborts the job immediately, and no partial result is emitted.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with length!=0: latch remaining=length, clear accumulator and overflow, go to ACCUM.
  - start=1 with length==0: clear accumulator and overflow, go to DONE (result 0).
- ACCUM:
  - in_ready=1 (combinational from state).
  - A beat is accepted when in_valid&&in_ready. On that edge: acc <= acc + sext(a*b), where the product is a full 2*DATA_W signed product sign-extended to ACC_W. Remaining decrements by 1.
  - If the beat is accepted while remaining==1, go to DONE on the same edge. The accumulator then already includes the last product.
  - If in_valid=0, hold all state; there is no timeout.
- DONE:
  - out_valid=1, result=acc, in_ready=0.
  - Hold result and overflow stable until out_valid&&out_ready, then go to IDLE on that edge.
  - out_ready may already be high on the first DONE cycle; the result then takes exactly one cycle.
- Latency: out_valid rises on the cycle after the last accepted beat. Minimum job time is length+1 cycles plus one handshake cycle.
- start while not IDLE: ignored, with no effect on the job in progress.
- Next job: start in the IDLE cycle after the handshake may begin the next job. There is no back-to-back overlap between DONE and a new start.
- Overflow:
  - Detected when the accumulator operand sign equals the product sign but the sum sign differs.
  - Sets overflow, which stays set until the next job starts.
  - Without the optional feature the accumulator wraps modulo 2^ACC_W.
- a and b are don't-care when no beat is accepted; X on them must not propagate into state.

Optional Feature:
- Macro DOT_PRODUCT_SATURATE_EN.
- When defined: on detected overflow, the accumulator clamps to the signed maximum (positive overflow) or minimum (negative overflow). Later beats continue from the clamped value. The overflow flag still sets.
- When undefined: wrap-around arithmetic, overflow flag only.

Test Plan:
- Basic job: length=3, pairs (2,3),(-4,5),(7,-1) with in_valid held high -> in_ready high for 3 cycles; out_valid one cycle after the third beat; result=-21; overflow=0.
- Zero length: start with length=0 -> in_ready never asserts; out_valid next cycle; result=0; out_ready=1 returns to IDLE in one cycle.
- Backpressure/bubbles: length=4, all pairs (1,1), in_valid toggled 1,0,1,0,... and out_ready held 0 for 5 cycles -> result=4 held stable with out_valid=1 until out_ready rises, then busy=0 the next cycle.
- Overflow (DATA_W=16, ACC_W=32): length=3, pairs (-32768,-32768) x3 -> without the macro, result wraps to 0xC0000000 (wrapped value) with overflow=1; with DOT_PRODUCT_SATURATE_EN, result=0x7FFFFFFF with overflow=1.
- Start ignored / reset mid-job: second start with length=9 during ACCUM of a length=2 job -> result reflects only 2 beats. Separately, assert reset_L=0 after 1 beat of a length=5 job -> busy=0, out_valid=0, result=0 immediately with no clock edge; a fresh job afterward is correct.
